// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - duck sprite palette constants and types
package duck_pkg;

    typedef logic [3:0] pal_idx_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb12_t;

    localparam logic [11:0] CHROMA_KEY = 12'hAEA;

    // Index 0 is the leftmost entry
    localparam logic [0:15][11:0] DUCK_PALETTE = {
        12'hAEA, 12'h00A, 12'hF76, 12'hFFF,
        12'hB0B, 12'hAEA, 12'hB0B, 12'hFFF,
        12'hFFF, 12'hFFF, 12'hFFF, 12'hB0B,
        12'hB0B, 12'hFFF, 12'hFFF, 12'hB0B
    };

    function automatic rgb12_t pal_lookup(input pal_idx_t idx);
        return rgb12_t'(DUCK_PALETTE[idx]);
    endfunction

endpackage

// File: rtl/duck_rr_arbiter.sv
// rtl/duck_rr_arbiter.sv - combinational round-robin picker starting at rr_ptr
module duck_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner
);

    logic          found;
    logic [ID_W:0] cand_w;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand_w = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Candidate (rr_ptr + k) mod N_REQ, one extra bit to catch the wrap
            cand_w = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand_w >= (ID_W+1)'(N_REQ)) begin
                cand_w = cand_w - (ID_W+1)'(N_REQ);
            end
            cand = cand_w[ID_W-1:0];
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

endmodule

// File: rtl/duck_palette_arbiter.sv
// rtl/duck_palette_arbiter.sv - shared duck palette lookup, RR arbitration, 2-stage pipeline
// Optional rsp_transparent output when DUCK_PAL_TRANSP_EN is defined.
module duck_palette_arbiter
    import duck_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IDX_W-1:0] req_index,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [3:0]             rsp_red,
    output logic [3:0]             rsp_green,
    output logic [3:0]             rsp_blue
`ifdef DUCK_PAL_TRANSP_EN
    ,
    output logic                   rsp_transparent
`endif
);

    logic             a_valid;
    logic [ID_W-1:0]  a_id;
    logic [IDX_W-1:0] a_index;
    logic [ID_W-1:0]  rr_ptr;
    rgb12_t           rsp_rgb;

    logic             advance_a;
    logic             advance_b;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_id;
    logic [IDX_W-1:0] win_index;
    logic             xfer;
    rgb12_t           a_rgb;

    assign advance_b = !rsp_valid || rsp_ready;
    assign advance_a = !a_valid || advance_b;

    duck_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .enable (advance_a),
        .grant  (grant),
        .winner (win_id)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign win_index = req_index[win_id*IDX_W +: IDX_W];
    assign a_rgb     = pal_lookup(pal_idx_t'(a_index));

    assign rsp_red   = rsp_rgb.red;
    assign rsp_green = rsp_rgb.green;
    assign rsp_blue  = rsp_rgb.blue;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_valid   <= 1'b0;
            a_id      <= '0;
            a_index   <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rgb   <= '0;
        end else begin
            if (advance_a) begin
                a_valid <= xfer;
                if (xfer) begin
                    a_id    <= win_id;
                    a_index <= win_index;
                end
            end
            if (xfer) begin
                rr_ptr <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
            end
            // Stage B reloads whenever it is empty or being drained
            if (advance_b) begin
                rsp_valid <= a_valid;
                if (a_valid) begin
                    rsp_id  <= a_id;
                    rsp_rgb <= a_rgb;
                end
            end
        end
    end

`ifdef DUCK_PAL_TRANSP_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rsp_transparent <= 1'b0;
        end else if (advance_b && a_valid) begin
            rsp_transparent <= (a_rgb == rgb12_t'(CHROMA_KEY));
        end
    end
`endif

endmodule

// File: tb/tb_duck_palette_arbiter.sv
// tb/tb_duck_palette_arbiter.sv - randomized and directed bench with a queue reference model
module tb_duck_palette_arbiter;

    localparam int N   = 4;
    localparam int IW  = 4;
    localparam int IDW = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [N-1:0]  req_valid;
    logic [N*IW-1:0] req_index;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [3:0]    rsp_red, rsp_green, rsp_blue;
`ifdef DUCK_PAL_TRANSP_EN
    logic          rsp_transparent;
`endif

    duck_palette_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_red   (rsp_red),
        .rsp_green (rsp_green),
        .rsp_blue  (rsp_blue)
`ifdef DUCK_PAL_TRANSP_EN
        ,
        .rsp_transparent (rsp_transparent)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int id;
        int idx;
        int t;
    } ent_t;

    ent_t q[$];
    int   rr = 0;
    int   now = 0;

    logic [N-1:0]   exp_grant;
    logic           exp_v;
    logic [IDW-1:0] exp_id;
    logic [11:0]    exp_rgb;

    function automatic logic [11:0] pal(input int i);
        case (i)
            0, 5:              return 12'hAEA;
            1:                 return 12'h00A;
            2:                 return 12'hF76;
            4, 6, 11, 12, 15:  return 12'hB0B;
            default:           return 12'hFFF;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        rr  = 0;
        now = 0;
    endtask

    // Capacity-2 queue: accept if room, or if the consumer frees a slot this cycle
    task automatic model_predict();
        int w;
        w = -1;
        exp_grant = '0;
        if (q.size() < 2 || rsp_ready) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        if (w >= 0) exp_grant[w] = 1'b1;
        exp_v = (q.size() > 0) && (now >= q[0].t + 2);
        exp_id = '0;
        exp_rgb = '0;
        if (exp_v) begin
            exp_id  = IDW'(q[0].id);
            exp_rgb = pal(q[0].idx);
        end
    endtask

    task automatic model_advance();
        logic taking;
        int   w;
        ent_t e;
        taking = exp_v && rsp_ready;
        w = -1;
        for (int i = 0; i < N; i++) if (exp_grant[i]) w = i;
        if (w >= 0) begin
            e.id  = w;
            e.idx = int'(req_index[w*IW +: IW]);
            e.t   = now;
        end
        @(posedge Clk);
        if (taking) void'(q.pop_front());
        if (w >= 0) begin
            q.push_back(e);
            rr = (w + 1) % N;
        end
        now++;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        req_valid = '0;
        req_index = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        req_valid = '0;
        req_index = '0;
        rsp_ready = 1'b1;
        #3;
        checks++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue});
        end
        tick();
        Reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle req_ready=%b rsp_valid=%b exp 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_index = 16'h0200;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early got=%b exp=0", rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== {1'b1, 2'd2, 12'hF76}) begin
            failures++;
            $display("FAIL single_rsp got=%b/%0d/%h exp=1/2/F76", rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue});
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drop got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_fairness();
        logic [IDW-1:0] ids[5];
        logic [11:0]    cols[5];
        logic [IDW-1:0] eids[5];
        logic [11:0]    ecols[5];
        int n;
        eids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ecols = '{12'h00A, 12'hF76, 12'hFFF, 12'hB0B, 12'h00A};
        n = 0;
        do_reset();
        req_valid = 4'b1111;
        req_index = {4'd4, 4'd3, 4'd2, 4'd1};
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (req_ready !== 4'(1 << (c % 4))) begin
                failures++;
                $display("FAIL fair_grant cyc=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % 4)));
            end
            if (rsp_valid && n < 5) begin
                ids[n]  = rsp_id;
                cols[n] = {rsp_red, rsp_green, rsp_blue};
                n++;
            end
            tick();
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL fair_count got=%0d exp=5", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ids[i] !== eids[i] || cols[i] !== ecols[i]) begin
                failures++;
                $display("FAIL fair_seq i=%0d got=%0d/%h exp=%0d/%h", i, ids[i], cols[i], eids[i], ecols[i]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int accepts;
        logic [15:0] prev;
        logic stalled;
        accepts = 0;
        stalled = 1'b0;
        prev = '0;
        do_reset();
        req_valid = 4'b1111;
        req_index = {4'd9, 4'd12, 4'd5, 4'd2};
        for (int c = 0; c < 16; c++) begin
            rsp_ready = !(c < 6);
            if (c >= 10) req_valid = '0;
            #1;
            model_predict();
            checks++;
            if (req_ready !== exp_grant) begin
                failures++;
                $display("FAIL bp_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_grant);
            end
            checks++;
            if (rsp_valid !== exp_v) begin
                failures++;
                $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({rsp_id, rsp_red, rsp_green, rsp_blue} !== {exp_id, exp_rgb}) begin
                    failures++;
                    $display("FAIL bp_data cyc=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, {rsp_red, rsp_green, rsp_blue}, exp_id, exp_rgb);
                end
            end
            if (stalled) begin
                checks++;
                if ({rsp_id, rsp_red, rsp_green, rsp_blue} !== prev[IDW+11:0]) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got=%h exp=%h", c, {rsp_id, rsp_red, rsp_green, rsp_blue}, prev[IDW+11:0]);
                end
            end
            if (c < 6 && |(req_valid & req_ready)) accepts++;
            stalled = rsp_valid && !rsp_ready;
            prev = 16'({rsp_id, rsp_red, rsp_green, rsp_blue});
            model_advance();
        end
        checks++;
        if (accepts != 2) begin
            failures++;
            $display("FAIL bp_accepts got=%0d exp=2", accepts);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_first got=%b exp=1000", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_second got=%b exp=0001", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_third got=%b exp=1000", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        req_index = {4'd3, 4'd4, 4'd1, 4'd2};
        #1;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_full got=%b exp=1", rsp_valid);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== '0) begin
            failures++;
            $display("FAIL arst_immediate got=%h exp=0", {rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue});
        end
        req_valid = '0;
        tick();
        Reset = 1'b0;
        model_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL arst_stale cyc=%0d got=%b exp=0", c, rsp_valid);
            end
            tick();
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL arst_first_grant got=%b exp=0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_palette_sweep();
        int r;
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            req_valid = '0;
            req_index = '0;
            if (c < 16) begin
                r = $urandom_range(0, N-1);
                req_valid[r] = 1'b1;
                req_index[r*IW +: IW] = 4'(c);
            end
            #1;
            model_predict();
            checks++;
            if (req_ready !== exp_grant) begin
                failures++;
                $display("FAIL sweep_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_grant);
            end
            checks++;
            if (rsp_valid !== exp_v) begin
                failures++;
                $display("FAIL sweep_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({rsp_id, rsp_red, rsp_green, rsp_blue} !== {exp_id, exp_rgb}) begin
                    failures++;
                    $display("FAIL sweep_data cyc=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, {rsp_red, rsp_green, rsp_blue}, exp_id, exp_rgb);
                end
`ifdef DUCK_PAL_TRANSP_EN
                checks++;
                if (rsp_transparent !== (exp_rgb == 12'hAEA)) begin
                    failures++;
                    $display("FAIL sweep_transp cyc=%0d got=%b exp=%b", c, rsp_transparent, (exp_rgb == 12'hAEA));
                end
`endif
            end
            model_advance();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev_valid;
        logic [N-1:0] prev_ready;
        prev_valid = '0;
        prev_ready = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(prev_valid[i] && !prev_ready[i])) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_index[i*IW +: IW] = 4'($urandom_range(0, 15));
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            model_predict();
            checks++;
            if (req_ready !== exp_grant) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_grant);
            end
            checks++;
            if (rsp_valid !== exp_v) begin
                failures++;
                $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({rsp_id, rsp_red, rsp_green, rsp_blue} !== {exp_id, exp_rgb}) begin
                    failures++;
                    $display("FAIL rand_data cyc=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, {rsp_red, rsp_green, rsp_blue}, exp_id, exp_rgb);
                end
            end
            prev_valid = req_valid;
            prev_ready = req_ready;
            model_advance();
        end
        req_valid = '0;
    endtask

    initial begin
        Reset     = 1'b1;
        req_valid = '0;
        req_index = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_palette_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
